// File: rtl/call_system_multi_pkg.sv
// Shared width helpers and arbiter state encoding for the multi-station
// call-light controller.
package call_pkg;

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  typedef enum logic {
    ARB_IDLE,
    ARB_PRESENT
  } arb_state_e;

endpackage

// File: rtl/call_system_multi_if.sv
// Station request/cancel inputs, operator serve handshake and status outputs.
interface call_system_multi_if #(
  parameter int N_CH = 4
);
  import call_pkg::*;

  logic [N_CH-1:0]          call;
  logic [N_CH-1:0]          cancel;
  logic                     serve_ack;
  logic [N_CH-1:0]          light;
  logic [N_CH-1:0]          escalated;
  logic                     serve_valid;
  logic [ch_w(N_CH)-1:0]    serve_id;
  logic [cnt_w(N_CH)-1:0]   pending_count;

  modport slave (
    input  call, cancel, serve_ack,
    output light, escalated, serve_valid, serve_id, pending_count
  );

  modport master (
    output call, cancel, serve_ack,
    input  light, escalated, serve_valid, serve_id, pending_count
  );
endinterface

// File: rtl/call_system_multi_station.sv
// One station: call light, saturating escalation timer and overdue flag.
module call_station #(
  parameter int ESC_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic call,
  input  logic cancel,
  input  logic ack_hit,
  output logic light,
  output logic light_nxt,
  output logic escalated
);
  localparam int TW = $clog2(ESC_CYCLES + 1);
  localparam logic [TW-1:0] T_MAX = TW'(ESC_CYCLES);

  logic          light_q, light_d;
  logic          esc_q, esc_d;
  logic [TW-1:0] timer_q, timer_d;

  always_comb begin
    light_d = call | (light_q & ~cancel & ~ack_hit);
    timer_d = '0;
    // A lit station cleared and re-called in the same cycle starts a fresh wait.
    if (light_d && light_q && !(call && (cancel || ack_hit))) begin
      timer_d = (timer_q == T_MAX) ? timer_q : timer_q + 1'b1;
    end
    esc_d = light_d & (timer_d == T_MAX);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      light_q <= 1'b0;
      esc_q   <= 1'b0;
      timer_q <= '0;
    end else begin
      light_q <= light_d;
      esc_q   <= esc_d;
      timer_q <= timer_d;
    end
  end

  assign light     = light_q;
  assign light_nxt = light_d;
  assign escalated = esc_q;
endmodule

// File: rtl/call_system_multi.sv
// Multi-station call-light controller: per-station lights/timers plus a
// two-level (escalated first) round-robin arbiter with valid/ack serve handshake.
module call_system_multi
  import call_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int ESC_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  call_system_multi_if.slave   bus
);
  localparam int CH_W = ch_w(N_CH);
  localparam int CNT_W = cnt_w(N_CH);
  localparam int unsigned NU = N_CH;

  logic [N_CH-1:0] light, light_nxt, esc, ack_hit;
  logic [N_CH-1:0] cand, esc_cand;

  arb_state_e       state_q, state_d;
  logic             serve_valid_q, serve_valid_d;
  logic [CH_W-1:0]  serve_id_q, serve_id_d;
  logic [CH_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] pending_q, pending_d;

  logic             esc_found, norm_found;
  logic [CH_W-1:0]  esc_id, norm_id, idx;
  int unsigned      pos;

  for (genvar i = 0; i < N_CH; i++) begin : g_st
    assign ack_hit[i] = serve_valid_q & bus.serve_ack & (serve_id_q == CH_W'(i));

    call_station #(.ESC_CYCLES(ESC_CYCLES)) u_station (
      .clk       (clk),
      .reset     (reset),
      .call      (bus.call[i]),
      .cancel    (bus.cancel[i]),
      .ack_hit   (ack_hit[i]),
      .light     (light[i]),
      .light_nxt (light_nxt[i]),
      .escalated (esc[i])
    );
  end

  // Stations going dark on this edge are excluded so a dead station is never granted.
  assign cand     = light & light_nxt;
  assign esc_cand = esc & cand;

  always_comb begin
    esc_found  = 1'b0;
    norm_found = 1'b0;
    esc_id     = '0;
    norm_id    = '0;
    pos        = 0;
    idx        = '0;
    for (int unsigned off = 0; off < NU; off++) begin
      pos = 32'(rr_ptr_q) + off;
      if (pos >= NU) pos = pos - NU;
      idx = CH_W'(pos);
      if (!esc_found && esc_cand[idx]) begin
        esc_found = 1'b1;
        esc_id    = idx;
      end
      if (!norm_found && cand[idx]) begin
        norm_found = 1'b1;
        norm_id    = idx;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    serve_valid_d = serve_valid_q;
    serve_id_d    = serve_id_q;
    rr_ptr_d      = rr_ptr_q;
    pending_d     = CNT_W'($countones(light));
    case (state_q)
      ARB_IDLE: begin
        if (esc_found) begin
          state_d       = ARB_PRESENT;
          serve_valid_d = 1'b1;
          serve_id_d    = esc_id;
        end else if (norm_found) begin
          state_d       = ARB_PRESENT;
          serve_valid_d = 1'b1;
          serve_id_d    = norm_id;
        end
      end
      ARB_PRESENT: begin
        if (|ack_hit) begin
          state_d       = ARB_IDLE;
          serve_valid_d = 1'b0;
          rr_ptr_d      = (serve_id_q == CH_W'(N_CH - 1)) ? '0 : serve_id_q + 1'b1;
        end else if (!light_nxt[serve_id_q]) begin
          state_d       = ARB_IDLE;
          serve_valid_d = 1'b0;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ARB_IDLE;
      serve_valid_q <= 1'b0;
      serve_id_q    <= '0;
      rr_ptr_q      <= '0;
      pending_q     <= '0;
    end else begin
      state_q       <= state_d;
      serve_valid_q <= serve_valid_d;
      serve_id_q    <= serve_id_d;
      rr_ptr_q      <= rr_ptr_d;
      pending_q     <= pending_d;
    end
  end

  assign bus.light         = light;
  assign bus.escalated     = esc;
  assign bus.serve_valid   = serve_valid_q;
  assign bus.serve_id      = serve_id_q;
  assign bus.pending_count = pending_q;
endmodule

// File: tb/tb_call_system_multi.sv
// Directed bench for call_system_multi: expected presentations are queued by the
// stimulus and checked by an independent monitor; state snapshots checked inline.
module tb_call_system_multi;
  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   exp_q[$];
  logic prev_valid = 1'b0;

  call_system_multi_if #(.N_CH(4)) bus ();

  call_system_multi #(.N_CH(4), .ESC_CYCLES(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every new presentation must match the next queued station id.
  always @(negedge clk) begin
    if (bus.serve_valid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_present: got id %0d, expected no presentation", bus.serve_id);
      end else begin
        check("serve_id", 32'(bus.serve_id), 32'(exp_q.pop_front()));
      end
    end
    prev_valid = bus.serve_valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    bus.call = '0;
    bus.cancel = '0;
    bus.serve_ack = 1'b0;
    repeat (3) tick();
    check("rst_light", 32'(bus.light), 0);
    check("rst_esc", 32'(bus.escalated), 0);
    check("rst_valid", 32'(bus.serve_valid), 0);
    check("rst_id", 32'(bus.serve_id), 0);
    check("rst_pc", 32'(bus.pending_count), 0);
    reset = 1'b0;
    tick();

    // Single call on station 2
    bus.call = 4'b0100; exp_q.push_back(2);
    tick(); bus.call = '0;
    check("t1_light", 32'(bus.light), 32'h4);
    check("t1_valid0", 32'(bus.serve_valid), 0);
    tick();
    check("t1_valid1", 32'(bus.serve_valid), 1);
    check("t1_pc", 32'(bus.pending_count), 1);
    bus.serve_ack = 1'b1;
    tick(); bus.serve_ack = 1'b0;
    check("t1_light_ack", 32'(bus.light), 0);
    check("t1_valid_ack", 32'(bus.serve_valid), 0);
    tick();
    check("t1_pc0", 32'(bus.pending_count), 0);

    // Call/cancel precedence, then withdrawal
    bus.call = 4'b0001; bus.cancel = 4'b0001; exp_q.push_back(0);
    tick(); bus.call = '0; bus.cancel = '0;
    check("t2_light", 32'(bus.light), 32'h1);
    tick();
    check("t2_valid", 32'(bus.serve_valid), 1);
    bus.cancel = 4'b0001;
    tick(); bus.cancel = '0;
    check("t2_light_wd", 32'(bus.light), 0);
    check("t2_valid_wd", 32'(bus.serve_valid), 0);
    tick(); tick();
    check("t2_valid_idle", 32'(bus.serve_valid), 0);

    // Round-robin over stations 0,1,3 from a fresh pointer
    reset = 1'b1; tick(); reset = 1'b0;
    bus.call = 4'b1011;
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(3);
    tick(); bus.call = '0;
    tick();
    check("t3_valid_first", 32'(bus.serve_valid), 1);
    for (int i = 0; i < 3; i++) begin
      bus.serve_ack = 1'b1;
      tick(); bus.serve_ack = 1'b0;
      check("t3_bubble", 32'(bus.serve_valid), 0);
      tick();
      if (i < 2) check("t3_valid_next", 32'(bus.serve_valid), 1);
    end
    check("t3_light_done", 32'(bus.light), 0);

    // Escalation priority: station 2 holds the operator while 1 and 3 wait
    bus.call = 4'b0100; exp_q.push_back(2);
    tick(); bus.call = '0;          // edge j
    tick();                         // j+1: presenting 2
    bus.call = 4'b0010;
    tick(); bus.call = '0;          // edge k = j+2
    repeat (4) tick();              // k+4
    bus.call = 4'b1000;
    tick(); bus.call = '0;          // k+5
    repeat (10) tick();             // k+15
    check("t4_esc_k15", 32'(bus.escalated), 32'h4);
    tick();                         // k+16
    check("t4_esc_k16", 32'(bus.escalated), 32'h6);
    check("t4_light", 32'(bus.light), 32'hE);
    check("t4_pc", 32'(bus.pending_count), 3);
    bus.serve_ack = 1'b1;
    exp_q.push_back(1); exp_q.push_back(3);
    tick(); bus.serve_ack = 1'b0;   // k+17: station 2 served, rr_ptr -> 3
    check("t4_light_ack2", 32'(bus.light), 32'hA);
    check("t4_esc_ack2", 32'(bus.escalated), 32'h2);
    check("t4_bubble", 32'(bus.serve_valid), 0);
    tick();
    check("t4_valid_esc", 32'(bus.serve_valid), 1);
    bus.serve_ack = 1'b1;
    tick(); bus.serve_ack = 1'b0;
    check("t4_light_ack1", 32'(bus.light), 32'h8);
    tick();
    check("t4_valid_3", 32'(bus.serve_valid), 1);
    bus.serve_ack = 1'b1;
    tick(); bus.serve_ack = 1'b0;
    check("t4_light_done", 32'(bus.light), 0);
    tick();

    // Ack and re-call on the same cycle restarts the wait
    bus.call = 4'b0001; exp_q.push_back(0);
    tick(); bus.call = '0;          // m
    tick();                         // m+1
    repeat (3) tick();              // m+4
    bus.serve_ack = 1'b1; bus.call = 4'b0001; exp_q.push_back(0);
    tick(); bus.serve_ack = 1'b0; bus.call = '0;  // m+5
    check("t5_light", 32'(bus.light), 32'h1);
    check("t5_bubble", 32'(bus.serve_valid), 0);
    check("t5_esc", 32'(bus.escalated), 0);
    tick();                         // m+6
    check("t5_represent", 32'(bus.serve_valid), 1);
    repeat (14) tick();             // m+20
    check("t5_esc_m20", 32'(bus.escalated), 0);
    tick();                         // m+21
    check("t5_esc_m21", 32'(bus.escalated), 32'h1);
    bus.serve_ack = 1'b1;
    tick(); bus.serve_ack = 1'b0;
    check("t5_light_done", 32'(bus.light), 0);
    tick();

    // Reset during a presentation with three lights, one escalated
    bus.call = 4'b0001; exp_q.push_back(0);
    tick(); bus.call = '0;          // r
    tick(); tick();                 // r+2
    bus.call = 4'b0110;
    tick(); bus.call = '0;          // r+3
    repeat (13) tick();             // r+16
    check("t6_light", 32'(bus.light), 32'h7);
    check("t6_esc", 32'(bus.escalated), 32'h1);
    check("t6_valid", 32'(bus.serve_valid), 1);
    check("t6_pc", 32'(bus.pending_count), 3);
    reset = 1'b1; bus.serve_ack = 1'b1; bus.call = 4'b1000;
    tick();
    check("t6_rst_light", 32'(bus.light), 0);
    check("t6_rst_esc", 32'(bus.escalated), 0);
    check("t6_rst_valid", 32'(bus.serve_valid), 0);
    check("t6_rst_id", 32'(bus.serve_id), 0);
    check("t6_rst_pc", 32'(bus.pending_count), 0);
    reset = 1'b0; bus.serve_ack = 1'b0; exp_q.push_back(3);
    tick(); bus.call = '0;
    check("t6_held_call", 32'(bus.light), 32'h8);
    check("t6_held_valid", 32'(bus.serve_valid), 0);
    tick();
    check("t6_present3", 32'(bus.serve_valid), 1);
    bus.serve_ack = 1'b1;
    tick(); bus.serve_ack = 1'b0;
    check("t6_light_done", 32'(bus.light), 0);
    repeat (3) tick();
    check("queue_drained", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
